// File: rtl/writeback_trace_buffer.sv
// Writeback trace buffer: records register writebacks of the pipelined core in a circular FIFO,
// keeps saturating stall/forwarding counters and flags a halted program (PC stuck without stall).
module writeback_trace_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_SEL_WIDTH = 5,
    parameter int FWD_WIDTH     = 2,
    parameter int DEPTH         = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int HALT_CYCLES   = 8,
    parameter int WRAP_MODE     = 0
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [DATA_WIDTH-1:0]     i_program_counter,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic                      i_reg_write,
    input  logic [REG_SEL_WIDTH-1:0]  i_rdest,
    input  logic                      i_stall,
    input  logic [FWD_WIDTH-1:0]      i_alu_src_a,
    input  logic [FWD_WIDTH-1:0]      i_alu_src_b,
    input  logic                      i_rd_req,
    output logic                      o_rd_valid,
    output logic [DATA_WIDTH-1:0]     o_rd_pc,
    output logic [REG_SEL_WIDTH-1:0]  o_rd_dest,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_full,
    output logic                      o_empty,
    output logic                      o_overflow,
    output logic [CNT_WIDTH-1:0]      o_stall_count,
    output logic [CNT_WIDTH-1:0]      o_fwd_count,
    output logic                      o_halted
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int RUN_W = $clog2(HALT_CYCLES);

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_HALTED  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [DATA_WIDTH-1:0]      r_mem_pc   [DEPTH];
    logic [REG_SEL_WIDTH-1:0]   r_mem_dest [DEPTH];
    logic [DATA_WIDTH-1:0]      r_mem_data [DEPTH];
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic                       r_overflow;
    logic                       r_rd_valid;
    logic [DATA_WIDTH-1:0]      r_rd_pc;
    logic [REG_SEL_WIDTH-1:0]   r_rd_dest;
    logic [DATA_WIDTH-1:0]      r_rd_data;
    logic [CNT_WIDTH-1:0]       r_stall_cnt;
    logic [CNT_WIDTH-1:0]       r_fwd_cnt;
    logic [DATA_WIDTH-1:0]      r_prev_pc;
    logic                       r_prev_valid;
    logic [RUN_W-1:0]           r_run;

    logic w_active, w_full, w_empty, w_cap, w_pop;
    logic w_store, w_overwrite, w_count_inc, w_pc_same, w_halt_hit, w_fwd;

    assign w_active    = i_enable & (r_state == ST_CAPTURE);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == CW'(0));
    assign w_cap       = w_active & i_reg_write & (i_rdest != '0);
    assign w_pop       = i_rd_req & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO only loses data when nothing is read.
    assign w_store     = w_cap & (~w_full | w_pop | (WRAP_MODE != 0));
    assign w_overwrite = w_cap & w_full & ~w_pop & (WRAP_MODE != 0);
    assign w_count_inc = w_store & ~w_overwrite;
    assign w_pc_same   = r_prev_valid & (i_program_counter == r_prev_pc) & ~i_stall;
    assign w_halt_hit  = w_active & w_pc_same & (r_run == RUN_W'(HALT_CYCLES - 2));
    assign w_fwd       = (i_alu_src_a != '0) | (i_alu_src_b != '0);

    // Next-state logic: halt is sticky until reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CAPTURE: begin
                if (w_halt_hit) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_CAPTURE;
        endcase
    end

    // Trace storage, deliberately left without reset.
    always_ff @(posedge i_clock) begin
        if (w_store) begin
            r_mem_pc[r_wr_ptr]   <= i_program_counter;
            r_mem_dest[r_wr_ptr] <= i_rdest;
            r_mem_data[r_wr_ptr] <= i_write_data;
        end
    end

    // Control state, pointers, read port, counters and halt detection.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_CAPTURE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_pc      <= '0;
            r_rd_dest    <= '0;
            r_rd_data    <= '0;
            r_stall_cnt  <= '0;
            r_fwd_cnt    <= '0;
            r_prev_pc    <= '0;
            r_prev_valid <= 1'b0;
            r_run        <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_pc   <= r_mem_pc[r_rd_ptr];
                r_rd_dest <= r_mem_dest[r_rd_ptr];
                r_rd_data <= r_mem_data[r_rd_ptr];
            end
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop | w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_count_inc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_cap & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_active) begin
                if (i_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
                    r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
                end
                if (w_fwd && (r_fwd_cnt != {CNT_WIDTH{1'b1}})) begin
                    r_fwd_cnt <= r_fwd_cnt + CNT_WIDTH'(1);
                end
                r_run        <= w_pc_same ? (r_run + RUN_W'(1)) : RUN_W'(0);
                r_prev_pc    <= i_program_counter;
                r_prev_valid <= 1'b1;
            end
        end
    end

    assign o_rd_valid    = r_rd_valid;
    assign o_rd_pc       = r_rd_pc;
    assign o_rd_dest     = r_rd_dest;
    assign o_rd_data     = r_rd_data;
    assign o_count       = r_count;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_overflow    = r_overflow;
    assign o_stall_count = r_stall_cnt;
    assign o_fwd_count   = r_fwd_cnt;
    assign o_halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_writeback_trace_buffer.sv
// Bench for writeback_trace_buffer: a stop-when-full and a wrap-mode instance share stimulus and are
// compared every cycle against a queue-based reference model, with directed and random phases.
module tb_writeback_trace_buffer;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int FW = 2;
    localparam int DEPTH = 4;
    localparam int CNTW = 4;
    localparam int HALT = 4;

    logic          clk;
    logic          reset, en, rw, stall, rd_req;
    logic [DW-1:0] pc, wdata;
    logic [RW-1:0] rdest;
    logic [FW-1:0] asa, asb;

    logic          o_rv    [2];
    logic [DW-1:0] o_rpc   [2];
    logic [RW-1:0] o_rdest [2];
    logic [DW-1:0] o_rdata [2];
    logic [2:0]    o_cnt   [2];
    logic          o_full  [2];
    logic          o_empty [2];
    logic          o_ovf   [2];
    logic [CNTW-1:0] o_stc [2];
    logic [CNTW-1:0] o_fwc [2];
    logic          o_halt  [2];

    int vectors = 0;
    int miscompares = 0;
    bit hold_pc = 0;

    // Reference model state
    logic [68:0]   mq0[$];
    logic [68:0]   mq1[$];
    bit            m_ovf [2];
    bit            m_rv  [2];
    logic [DW-1:0] m_rpc [2];
    logic [RW-1:0] m_rdest [2];
    logic [DW-1:0] m_rdata [2];
    int            m_stall, m_fwd, m_run;
    bit            m_halted, m_prev_valid;
    logic [DW-1:0] m_prev_pc;

    initial clk = 1'b0;
    always #75 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        writeback_trace_buffer #(
            .DATA_WIDTH(DW), .REG_SEL_WIDTH(RW), .FWD_WIDTH(FW), .DEPTH(DEPTH),
            .CNT_WIDTH(CNTW), .HALT_CYCLES(HALT), .WRAP_MODE(g)
        ) dut (
            .i_clock(clk), .i_reset(reset), .i_enable(en),
            .i_program_counter(pc), .i_write_data(wdata), .i_reg_write(rw),
            .i_rdest(rdest), .i_stall(stall), .i_alu_src_a(asa), .i_alu_src_b(asb),
            .i_rd_req(rd_req),
            .o_rd_valid(o_rv[g]), .o_rd_pc(o_rpc[g]), .o_rd_dest(o_rdest[g]),
            .o_rd_data(o_rdata[g]), .o_count(o_cnt[g]), .o_full(o_full[g]),
            .o_empty(o_empty[g]), .o_overflow(o_ovf[g]), .o_stall_count(o_stc[g]),
            .o_fwd_count(o_fwc[g]), .o_halted(o_halt[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [68:0] q[$];
        logic [68:0] e;
        bit cap;
        if (reset) begin
            mq0.delete();
            mq1.delete();
            for (int m = 0; m < 2; m++) begin
                m_ovf[m] = 0; m_rv[m] = 0; m_rpc[m] = '0; m_rdest[m] = '0; m_rdata[m] = '0;
            end
            m_stall = 0; m_fwd = 0; m_run = 0; m_halted = 0; m_prev_valid = 0; m_prev_pc = '0;
        end else begin
            cap = en && rw && (rdest != 0) && !m_halted;
            for (int m = 0; m < 2; m++) begin
                if (m == 0) q = mq0; else q = mq1;
                m_rv[m] = 0;
                if (rd_req && q.size() > 0) begin
                    e = q.pop_front();
                    m_rv[m] = 1;
                    m_rpc[m] = e[68:37]; m_rdest[m] = e[36:32]; m_rdata[m] = e[31:0];
                end
                if (cap) begin
                    if (q.size() < DEPTH) begin
                        q.push_back({pc, rdest, wdata});
                    end else begin
                        m_ovf[m] = 1;
                        if (m == 1) begin
                            e = q.pop_front();
                            q.push_back({pc, rdest, wdata});
                        end
                    end
                end
                if (m == 0) mq0 = q; else mq1 = q;
            end
            if (en && !m_halted) begin
                if (stall && m_stall < (1 << CNTW) - 1) m_stall++;
                if ((asa != 0 || asb != 0) && m_fwd < (1 << CNTW) - 1) m_fwd++;
                if (m_prev_valid && pc == m_prev_pc && !stall) m_run++; else m_run = 0;
                if (m_run == HALT - 1) m_halted = 1;
                m_prev_pc = pc;
                m_prev_valid = 1;
            end
        end
    endtask

    task automatic check_all();
        int sz;
        for (int m = 0; m < 2; m++) begin
            sz = (m == 0) ? mq0.size() : mq1.size();
            chk($sformatf("d%0d.count", m), o_cnt[m], sz);
            chk($sformatf("d%0d.full", m), o_full[m], (sz == DEPTH));
            chk($sformatf("d%0d.empty", m), o_empty[m], (sz == 0));
            chk($sformatf("d%0d.overflow", m), o_ovf[m], m_ovf[m]);
            chk($sformatf("d%0d.rd_valid", m), o_rv[m], m_rv[m]);
            chk($sformatf("d%0d.rd_pc", m), o_rpc[m], m_rpc[m]);
            chk($sformatf("d%0d.rd_dest", m), o_rdest[m], m_rdest[m]);
            chk($sformatf("d%0d.rd_data", m), o_rdata[m], m_rdata[m]);
            chk($sformatf("d%0d.stall_cnt", m), o_stc[m], m_stall);
            chk($sformatf("d%0d.fwd_cnt", m), o_fwc[m], m_fwd);
            chk($sformatf("d%0d.halted", m), o_halt[m], m_halted);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        if (!hold_pc) pc = pc + 32'd4;
    endtask

    task automatic do_reset();
        reset = 1'b1; rw = 1'b0; rd_req = 1'b0; stall = 1'b0; asa = '0; asb = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic writeback(input logic [DW-1:0] p, input logic [RW-1:0] d, input logic [DW-1:0] dat);
        pc = p; rdest = d; wdata = dat; rw = 1'b1;
        tick();
        rw = 1'b0;
    endtask

    task automatic pop();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; pc = 32'h0; wdata = 32'h0; rw = 1'b0; rdest = 5'd0;
        stall = 1'b0; asa = 2'd0; asb = 2'd0; rd_req = 1'b0;
        do_reset();
        chk("reset.empty", o_empty[0], 1'b1);
        chk("reset.count", o_cnt[0], 3'd0);

        // Basic capture and in-order read-out
        writeback(32'h04, 5'd8, 32'h11);
        writeback(32'h08, 5'd9, 32'h22);
        writeback(32'h0C, 5'd10, 32'h33);
        chk("basic.count3", o_cnt[0], 3'd3);
        pop();
        chk("basic.pop1", {o_rv[0], o_rpc[0], o_rdest[0], o_rdata[0]}, {1'b1, 32'h04, 5'd8, 32'h11});
        pop();
        chk("basic.pop2", {o_rv[0], o_rpc[0], o_rdest[0], o_rdata[0]}, {1'b1, 32'h08, 5'd9, 32'h22});
        pop();
        chk("basic.pop3", {o_rv[0], o_rpc[0], o_rdest[0], o_rdata[0]}, {1'b1, 32'h0C, 5'd10, 32'h33});
        chk("basic.empty", o_empty[0], 1'b1);
        tick();
        chk("basic.rv_low", o_rv[0], 1'b0);

        // Overfill: stop mode keeps 1..4, wrap mode keeps 3..6
        for (int i = 1; i <= 6; i++) writeback(32'h100 + 32'(i * 4), 5'd3, 32'(i));
        chk("full.stop", {o_full[0], o_ovf[0]}, 2'b11);
        chk("full.wrap", {o_full[1], o_ovf[1]}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            pop();
            chk($sformatf("stop.pop%0d", i), o_rdata[0], 32'(i + 1));
            chk($sformatf("wrap.pop%0d", i), o_rdata[1], 32'(i + 3));
        end

        // Capture into full FIFO with simultaneous pop: stored, no overflow
        do_reset();
        for (int i = 0; i < 4; i++) writeback(32'h200 + 32'(i * 4), 5'd4, 32'hA0 + 32'(i));
        rd_req = 1'b1;
        writeback(32'h300, 5'd4, 32'hBB);
        rd_req = 1'b0;
        chk("fullpop.ovf", {o_ovf[0], o_ovf[1], o_cnt[0]}, {1'b0, 1'b0, 3'd4});

        // RDest=0 is not captured; read on empty ignored
        do_reset();
        writeback(32'h400, 5'd0, 32'hDEAD);
        pop();
        chk("rd0.count", o_cnt[0], 3'd0);
        chk("rd0.rv", o_rv[0], 1'b0);

        // Stall / forwarding counters
        stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        asa = 2'd2;
        repeat (3) tick();
        asa = 2'd0;
        chk("cnt.stall5", o_stc[0], 4'd5);
        chk("cnt.fwd3", o_fwc[0], 4'd3);
        do_reset();
        stall = 1'b1;
        repeat (20) tick();
        stall = 1'b0;
        chk("cnt.sat", o_stc[0], 4'd15);

        // Halt detection at a stuck PC
        hold_pc = 1;
        pc = 32'h40;
        do_reset();
        repeat (3) tick();
        chk("halt.not_yet", o_halt[0], 1'b0);
        tick();
        chk("halt.set", o_halt[0], 1'b1);
        stall = 1'b1;
        asa = 2'd1;
        writeback(32'h40, 5'd7, 32'h77);
        stall = 1'b0;
        asa = 2'd0;
        chk("halt.nocap", o_cnt[0], 3'd0);
        chk("halt.frozen", {o_stc[0], o_fwc[0]}, 8'h00);

        // A single stall restarts the run
        do_reset();
        repeat (2) tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        repeat (2) tick();
        chk("halt.delayed", o_halt[0], 1'b0);
        tick();
        chk("halt.after_stall", o_halt[0], 1'b1);
        hold_pc = 0;

        // Reset dominates while full and reading
        do_reset();
        for (int i = 0; i < 5; i++) writeback(32'h500 + 32'(i * 4), 5'd2, 32'(i));
        rd_req = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_req = 1'b0;
        chk("rst.state", {o_cnt[0], o_empty[0], o_rv[0], o_ovf[0], o_halt[0]}, {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Random traffic against the reference model
        hold_pc = 1;
        for (int i = 0; i < 500; i++) begin
            reset  = ($urandom_range(0, 39) == 0);
            en     = ($urandom_range(0, 7) != 0);
            rw     = $urandom_range(0, 1);
            rdest  = 5'($urandom_range(0, 3));
            wdata  = $urandom;
            stall  = ($urandom_range(0, 5) == 0);
            asa    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            asb    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rd_req = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) != 0) pc = pc + 32'd4;
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
